obi_stream_read_dma: RTL and testbench
======================================

# obi_stream_read_dma

Parametrised OBI read DMA for the user domain: takes a (byte address, byte length) command, issues pipelined word reads on one OBI manager port, buffers responses in a local FIFO and emits them as a valid/ready word stream with byte enables and last flag. Next generation of the ASCON key/BDI read engines. It adds configurable outstanding-request depth, FIFO depth, abort, completion pulse and optional bus-error handling, so one engine serves any ASCON input channel.

## Interface
- `FifoDepth`, default 4: stream buffer depth in words. Power of two, ≥2.
- `MaxOutstanding`, default 2: maximum granted-but-unanswered OBI reads, 1..FifoDepth.
- `LenWidth`, default 16: width of the byte-length command field.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `testmode_i`  in  1  test mode. Unused functionally.
- `mgr_req_o`  out  mgr_obi_req_t  OBI manager request. Always reads: we=0, be=4'hF.
- `mgr_rsp_i`  in  mgr_obi_rsp_t  OBI manager response.
- `arvalid`/`arready`  in/out  1  command handshake.
- `araddr`  in  32  start byte address. Bits [1:0] ignored.
- `arlen`  in  LenWidth  length in bytes.
- `abort_i`  in  1  one-cycle abort request.
- `wvalid`/`wready`  out/in  1  output stream handshake.
- `wdata`  out  32  stream word.
- `wbe`  out  4  byte enables of the stream word.
- `wlast`  out  1  final word of the command.
- `busy_o`  out  1  command in progress.
- `done_o`  out  1  one-cycle completion pulse.
- `err_o`  out  1  sticky bus error. See Configuration.

## Operation
- States:
  - IDLE: `arready`=1.
  - ISSUE: requests remain to be issued.
  - DRAIN: all requests issued; waiting for responses and the stream.
  - FLUSH: abort in progress.
- IDLE: a command is accepted on `arvalid&arready`. It latches addr={araddr[31:2],2'b00}, words=ceil(arlen/4) and tail=arlen[1:0].
  - arlen=0: go straight to DRAIN with nothing to transfer. `done_o` pulses next cycle and no stream word is produced.
- ISSUE: `req` is asserted while outstanding<MaxOutstanding and outstanding+fifo_count<FifoDepth (credit).
  - `req` and `addr` are held stable until `gnt`.
  - On each `gnt`: addr+=4 (32-bit wrap, no error), issued++, outstanding++.
  - After the last grant, go to DRAIN.
- Every `rvalid` decrements outstanding and pushes `rdata` into the FIFO. Credit guarantees the push never overflows; `rvalid` is never backpressured.
- Stream output:
  - `wvalid`=FIFO non-empty; `wdata`=FIFO head.
  - `wlast`=1 when the head is the final word of the command.
  - `wbe`=4'hF, except on the last word when tail≠0, where wbe=(1<<tail)-1.
  - The head is popped on `wvalid&wready`.
- DRAIN → IDLE once the last word handshakes. `done_o` pulses that same cycle.
- `busy_o`=1 in any state other than IDLE.
- Abort (`abort_i` in ISSUE or DRAIN):
  - An un-granted `req` is dropped next cycle.
  - The FIFO is flushed and `wvalid`=0.
  - FLUSH discards the responses of outstanding requests, then returns to IDLE when outstanding=0.
  - No `done_o` pulse.
  - `abort_i` in IDLE is ignored.
  - If abort coincides with the final stream handshake, completion wins.
- Simultaneous push and pop in one cycle leaves the FIFO count unchanged.
- Counters are LenWidth-1 bits wide (word counts).

## Timing
- Reset values: `mgr_req_o`='0, `arready`=1, `wvalid`=0, `wdata`=0, `wbe`=0, `wlast`=0, `busy_o`=0, `done_o`=0, `err_o`=0. Reset mid-operation returns to IDLE at once and discards all state.
- First `req` is asserted the cycle after command accept.
- FIFO is registered, no fall-through: `wvalid` rises the cycle after the `rvalid` push.
- Latency with a zero-wait slave (gnt same cycle, rvalid next cycle) and `wready`=1: accept at cycle 0, req/gnt at 1, rvalid at 2, wvalid at 3.
- Throughput is 1 word/cycle when MaxOutstanding≥2. With MaxOutstanding=1 it is 1 word per 2 cycles.
- `wdata`/`wbe`/`wlast` hold stable while `wvalid&!wready`.

## Configuration
- `OBI_DMA_ERR_EN` defined:
  - `rvalid` with `err`=1 sets `err_o`. `err_o` stays set until the next command accept.
  - That word and all later words of the command are not pushed.
  - The engine aborts internally (FLUSH) with `done_o` suppressed.
- `OBI_DMA_ERR_EN` undefined:
  - `err` is ignored and the data is passed through.
  - `err_o` is tied 0.

## Structure
- user_pkg:
  - `obi_dma_state_e` enum (IDLE, ISSUE, DRAIN, FLUSH).
  - `ObiDmaDefaultLenWidth` constant.
  - Reuses the existing `mgr_obi_req_t`/`mgr_obi_rsp_t`.
- Sub-module `obi_dma_fifo`: synchronous FIFO with parameter Depth, async active-low reset, push/pop/flush, count output (Depth+1 states) and data/last/be payload.

## Test plan
- araddr=0x1000_0002, arlen=12, zero-wait slave, wready=1 → reads at 0x1000_0000/04/08; 3 words, wbe=F,F,F; wlast on the 3rd; done_o pulses with the 3rd handshake.
- arlen=7 → 2 words; second word has wbe=4'b0111 and wlast=1.
- arlen=0 → no `req`; done_o pulses 1 cycle after accept; no wvalid.
- FifoDepth=4, arlen=64, wready=0 → exactly 4 grants then `req` stays low; release wready → all 16 words arrive in order with no drop.
- abort_i asserted 2 cycles after grant of word 2 of 8, MaxOutstanding=2 → no further req; late rvalids discarded; wvalid=0; busy_o falls once outstanding=0; no done_o.
- With OBI_DMA_ERR_EN: err=1 on word 3 of 5 → words 1-2 streamed, err_o=1, no done_o. Without the macro: all 5 words streamed and err_o=0.

Source files
------------

// File: rtl/user_pkg.sv
// Shared types for the user-domain OBI read DMA.
//   obi_dma_state_e  : engine state (idle, issuing, draining, flushing after abort/error)
//   mgr_obi_req_t    : OBI manager request bundle
//   mgr_obi_rsp_t    : OBI manager response bundle
//   obi_dma_word_t   : stream FIFO payload (data, byte enables, last flag)
package user_pkg;

  localparam int unsigned ObiDmaDefaultLenWidth = 16;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StFlush
  } obi_dma_state_e;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mgr_obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
  } mgr_obi_rsp_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  be;
    logic        last;
  } obi_dma_word_t;

  // Byte enables of the final word for a given length remainder; a zero remainder is a full word.
  function automatic logic [3:0] obi_dma_tail_be(input logic [1:0] tail);
    logic [3:0] be;
    case (tail)
      2'd1:    be = 4'b0001;
      2'd2:    be = 4'b0011;
      2'd3:    be = 4'b0111;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/obi_dma_fifo.sv
// Registered (no fall-through) synchronous FIFO for the DMA stream buffer.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   flush_i       : empty the FIFO; takes precedence over push
//   push_i/word_i : write one entry
//   pop_i         : remove the head entry
//   head_o        : current head entry (stale when empty)
//   empty_o       : no entries held
//   count_o       : number of entries held, 0..Depth
module obi_dma_fifo
  import user_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  obi_dma_word_t                word_i,
  input  logic                         pop_i,
  output obi_dma_word_t                head_o,
  output logic                         empty_o,
  output logic [$clog2(Depth+1)-1:0]   count_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  obi_dma_word_t   mem_q [Depth];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] cnt_q;
  logic            do_push, do_pop, full;

  assign full    = (cnt_q == CntW'(Depth));
  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i && (!full || do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= word_i;
        wptr_q        <= wptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rptr_q <= rptr_q + PtrW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign head_o  = mem_q[rptr_q];
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/obi_stream_read_dma.sv
// OBI read DMA: turns a (byte address, byte length) command into pipelined word reads on one
// OBI manager port and replays the responses as a valid/ready word stream with byte enables
// and a last flag.
//   clk_i, rst_ni           : clock, asynchronous active-low reset
//   testmode_i              : test mode, functionally unused
//   mgr_req_o / mgr_rsp_i   : OBI manager port (reads only)
//   arvalid/arready/araddr/arlen : command handshake
//   abort_i                 : one-cycle abort of the running command
//   wvalid/wready/wdata/wbe/wlast : output word stream
//   busy_o, done_o, err_o   : status; done_o pulses on normal completion only
// Build option: define OBI_DMA_ERR_EN to make bus errors stop the command and set err_o.
module obi_stream_read_dma
  import user_pkg::*;
#(
  parameter int unsigned FifoDepth      = 4,
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned LenWidth       = ObiDmaDefaultLenWidth
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                testmode_i,
  output mgr_obi_req_t        mgr_req_o,
  input  mgr_obi_rsp_t        mgr_rsp_i,
  input  logic                arvalid,
  output logic                arready,
  input  logic [31:0]         araddr,
  input  logic [LenWidth-1:0] arlen,
  input  logic                abort_i,
  output logic                wvalid,
  input  logic                wready,
  output logic [31:0]         wdata,
  output logic [3:0]          wbe,
  output logic                wlast,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o
);

  localparam int unsigned CntW = LenWidth - 1;
  localparam int unsigned OcW  = $clog2(FifoDepth + 1);
  localparam int unsigned SumW = OcW + 1;

  obi_dma_state_e  state_q, state_d;
  logic [31:0]     addr_q, addr_d;
  logic [CntW-1:0] words_q, words_d;
  logic [CntW-1:0] issued_q, issued_d;
  logic [CntW-1:0] pushed_q, pushed_d;
  logic [1:0]      tail_q, tail_d;
  logic [OcW-1:0]  outst_q, outst_d;

  obi_dma_word_t   push_word, head;
  logic            fifo_empty;
  logic [OcW-1:0]  fifo_cnt;

  logic [CntW-1:0] words_in;
  logic [SumW-1:0] inflight;
  logic            issue_req, gnt_acc, rsp_live, err_hit, abort_hit;
  logic            push, pop, push_last, last_hs, done_cond;

  assign words_in = CntW'(arlen[LenWidth-1:2]) + CntW'(arlen[1:0] != 2'b00);

  // Credit: a request is only issued if its response is guaranteed a FIFO slot, so rvalid
  // never needs backpressure. outstanding+count never grows without a grant, which keeps
  // req stable until gnt.
  assign inflight  = {1'b0, outst_q} + {1'b0, fifo_cnt};
  assign issue_req = (state_q == StIssue) && (issued_q != words_q) &&
                     (outst_q < OcW'(MaxOutstanding)) && (inflight < SumW'(FifoDepth));
  assign gnt_acc   = issue_req && mgr_rsp_i.gnt;

  assign rsp_live  = (state_q == StIssue) || (state_q == StDrain);

`ifdef OBI_DMA_ERR_EN
  logic err_q, err_d;
  logic unused_sig;
  assign unused_sig = testmode_i;
  assign err_hit    = mgr_rsp_i.rvalid && mgr_rsp_i.err && rsp_live;
  assign err_o      = err_q;
`else
  logic unused_sig;
  assign unused_sig = ^{testmode_i, mgr_rsp_i.err};
  assign err_hit    = 1'b0;
  assign err_o      = 1'b0;
`endif

  assign wvalid    = !fifo_empty;
  assign wdata     = head.data;
  assign wbe       = head.be;
  assign wlast     = head.last;
  assign pop       = wvalid && wready;
  assign last_hs   = pop && head.last;
  assign done_cond = (state_q == StDrain) && ((words_q == '0) || last_hs);

  // Completion wins over a coincident abort.
  assign abort_hit = abort_i && ((state_q == StIssue) || ((state_q == StDrain) && !done_cond));

  assign push      = mgr_rsp_i.rvalid && rsp_live && !abort_hit && !err_hit;
  assign push_last = ((pushed_q + CntW'(1)) == words_q);

  always_comb begin
    push_word      = '0;
    push_word.data = mgr_rsp_i.rdata;
    push_word.last = push_last;
    push_word.be   = push_last ? obi_dma_tail_be(tail_q) : 4'hF;
  end

  // An error stop keeps already-buffered words so they still stream out; only an abort
  // empties the FIFO.
  obi_dma_fifo #(
    .Depth (FifoDepth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (abort_hit),
    .push_i  (push),
    .word_i  (push_word),
    .pop_i   (pop),
    .head_o  (head),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  always_comb begin
    outst_d = outst_q + OcW'(gnt_acc);
    if (mgr_rsp_i.rvalid && (outst_q != '0)) begin
      outst_d = outst_d - OcW'(1);
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    words_d  = words_q;
    issued_d = issued_q;
    pushed_d = pushed_q;
    tail_d   = tail_q;
    arready  = 1'b0;
`ifdef OBI_DMA_ERR_EN
    err_d    = err_q | err_hit;
`endif

    if (gnt_acc) begin
      addr_d   = addr_q + 32'd4;
      issued_d = issued_q + CntW'(1);
    end
    if (push) begin
      pushed_d = pushed_q + CntW'(1);
    end

    unique case (state_q)
      StIdle: begin
        arready = 1'b1;
        if (arvalid) begin
          addr_d   = {araddr[31:2], 2'b00};
          words_d  = words_in;
          tail_d   = arlen[1:0];
          issued_d = '0;
          pushed_d = '0;
`ifdef OBI_DMA_ERR_EN
          err_d    = 1'b0;
`endif
          state_d  = (words_in == '0) ? StDrain : StIssue;
        end
      end
      StIssue: begin
        if (abort_hit || err_hit) begin
          state_d = StFlush;
        end else if (gnt_acc && ((issued_q + CntW'(1)) == words_q)) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (done_cond) begin
          state_d = StIdle;
        end else if (abort_hit || err_hit) begin
          state_d = StFlush;
        end
      end
      StFlush: begin
        if ((outst_q == '0) && fifo_empty) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      words_q  <= '0;
      issued_q <= '0;
      pushed_q <= '0;
      tail_q   <= '0;
      outst_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      words_q  <= words_d;
      issued_q <= issued_d;
      pushed_q <= pushed_d;
      tail_q   <= tail_d;
      outst_q  <= outst_d;
    end
  end

`ifdef OBI_DMA_ERR_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
`endif

  always_comb begin
    mgr_req_o      = '0;
    mgr_req_o.req  = issue_req;
    mgr_req_o.we   = 1'b0;
    mgr_req_o.be   = {4{issue_req}};
    mgr_req_o.addr = addr_q;
  end

  assign busy_o = (state_q != StIdle);
  assign done_o = done_cond;

endmodule

// File: tb/tb_obi_stream_read_dma.sv
`timescale 1ns/1ps
module tb_obi_stream_read_dma;
  import user_pkg::*;

  localparam int unsigned LenW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mgr_obi_req_t    req;
  mgr_obi_rsp_t    rsp;
  logic            arvalid = 1'b0;
  logic            arready;
  logic [31:0]     araddr = '0;
  logic [LenW-1:0] arlen = '0;
  logic            abort = 1'b0;
  logic            wvalid, wready = 1'b0;
  logic [31:0]     wdata;
  logic [3:0]      wbe;
  logic            wlast, busy, done, err;

  logic            gnt_en = 1'b0, rv = 1'b0, rerr = 1'b0;
  logic [31:0]     rd = '0;

  int checks = 0;
  int errors = 0;

  int gnt_pct = 100, rsp_pct = 100, wr_pct = 100;
  int err_at = -1;
  int resp_idx = 0;

  always_comb begin
    rsp        = '0;
    rsp.gnt    = req.req & gnt_en;
    rsp.rvalid = rv;
    rsp.rdata  = rd;
    rsp.err    = rerr;
  end

  obi_stream_read_dma dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .testmode_i (1'b0),
    .mgr_req_o  (req),
    .mgr_rsp_i  (rsp),
    .arvalid    (arvalid),
    .arready    (arready),
    .araddr     (araddr),
    .arlen      (arlen),
    .abort_i    (abort),
    .wvalid     (wvalid),
    .wready     (wready),
    .wdata      (wdata),
    .wbe        (wbe),
    .wlast      (wlast),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5EED_C0DE;
  endfunction

  // Memory slave: random grant, in-order responses at least one cycle after grant.
  logic [31:0] pend[$];
  always @(negedge clk) begin
    if (rst_n && req.req && rsp.gnt) pend.push_back(req.addr);
  end
  always @(posedge clk) begin
    #1;
    gnt_en = (int'($urandom_range(99)) < gnt_pct);
    wready = (int'($urandom_range(99)) < wr_pct);
    rv = 1'b0;
    rerr = 1'b0;
    rd = '0;
    if (pend.size() > 0 && int'($urandom_range(99)) < rsp_pct) begin
      rv = 1'b1;
      rd = memf(pend.pop_front());
      rerr = (resp_idx == err_at);
      resp_idx++;
    end
  end

  // Observer: stream capture, done tracking, stability of held stream word and request.
  logic [31:0] got_d[$];
  logic [3:0]  got_be[$];
  logic        got_l[$];
  logic [31:0] gnt_addr[$];
  int          done_cnt = 0, done_on_last = 0;
  logic        p_hold = 1'b0, p_req_hold = 1'b0;
  logic [31:0] p_wdata, p_addr;
  logic [3:0]  p_wbe;
  logic        p_wlast;

  always @(negedge clk) begin
    if (!rst_n) begin
      p_hold = 1'b0;
      p_req_hold = 1'b0;
    end else begin
      if (p_hold) begin
        checks++;
        if (wvalid !== 1'b1 || wdata !== p_wdata || wbe !== p_wbe || wlast !== p_wlast) begin
          errors++;
          $display("FAIL stream_hold: got v=%b d=%h be=%h l=%b expected v=1 d=%h be=%h l=%b",
                   wvalid, wdata, wbe, wlast, p_wdata, p_wbe, p_wlast);
        end
      end
      if (p_req_hold) begin
        checks++;
        if (req.req !== 1'b1 || req.addr !== p_addr) begin
          errors++;
          $display("FAIL req_hold: got req=%b addr=%h expected req=1 addr=%h",
                   req.req, req.addr, p_addr);
        end
      end
      if (wvalid && wready) begin
        got_d.push_back(wdata);
        got_be.push_back(wbe);
        got_l.push_back(wlast);
      end
      if (done) begin
        done_cnt++;
        if (wvalid && wready && wlast) done_on_last++;
      end
      if (req.req && rsp.gnt) gnt_addr.push_back(req.addr);
      p_hold     = wvalid && !wready && !abort;
      p_req_hold = req.req && !rsp.gnt && !abort && !(rv && rerr);
      p_wdata    = wdata;
      p_wbe      = wbe;
      p_wlast    = wlast;
      p_addr     = req.addr;
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_obs();
    got_d.delete();
    got_be.delete();
    got_l.delete();
    gnt_addr.delete();
    done_cnt = 0;
    done_on_last = 0;
    resp_idx = 0;
  endtask

  task automatic send_cmd(input logic [31:0] a, input int len);
    bit ok = 0;
    @(posedge clk); #1;
    arvalid = 1'b1;
    araddr  = a;
    arlen   = LenW'(len);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (arready) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL cmd_accept: got arready=0 expected arready=1 within 50 cycles");
    end
  endtask

  task automatic wait_idle(input string name);
    bit ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!busy && pend.size() == 0 && !rv) begin
        ok = 1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_idle: got busy=%b expected busy=0 within 3000 cycles", name, busy);
    end
  endtask

  // Reference: word i of a command reads base+4i; only the final word is partial/last.
  task automatic check_stream(input logic [31:0] a, input int len, input int nexp,
                              input bit chk_addr, input string name);
    logic [31:0] base;
    logic [31:0] exp_d;
    logic [3:0]  exp_be;
    logic        exp_l;
    int          nw, t;
    base = {a[31:2], 2'b00};
    nw   = (len + 3) / 4;
    t    = len % 4;
    checks++;
    if (got_d.size() != nexp) begin
      errors++;
      $display("FAIL %s_count: got %0d words expected %0d", name, got_d.size(), nexp);
    end
    for (int i = 0; i < nexp && i < got_d.size(); i++) begin
      exp_d  = memf(base + 32'(4 * i));
      exp_l  = (i == nw - 1);
      exp_be = (exp_l && t != 0) ? (4'hF >> (4 - t)) : 4'hF;
      checks++;
      if (got_d[i] !== exp_d || got_be[i] !== exp_be || got_l[i] !== exp_l) begin
        errors++;
        $display("FAIL %s_word%0d: got d=%h be=%h l=%b expected d=%h be=%h l=%b", name, i,
                 got_d[i], got_be[i], got_l[i], exp_d, exp_be, exp_l);
      end
    end
    if (chk_addr) begin
      checks++;
      if (gnt_addr.size() != nw) begin
        errors++;
        $display("FAIL %s_greqs: got %0d grants expected %0d", name, gnt_addr.size(), nw);
      end
      for (int i = 0; i < nw && i < gnt_addr.size(); i++) begin
        checks++;
        if (gnt_addr[i] !== base + 32'(4 * i)) begin
          errors++;
          $display("FAIL %s_addr%0d: got %h expected %h", name, i, gnt_addr[i],
                   base + 32'(4 * i));
        end
      end
    end
  endtask

  task automatic check_done(input int exp, input string name);
    checks++;
    if (done_cnt != exp) begin
      errors++;
      $display("FAIL %s_done: got %0d pulses expected %0d", name, done_cnt, exp);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (arready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: got rdy=%b busy=%b done=%b err=%b expected 1 0 0 0",
               arready, busy, done, err);
    end
    checks++;
    if (wvalid !== 1'b0 || wdata !== 32'h0 || wbe !== 4'h0 || wlast !== 1'b0) begin
      errors++;
      $display("FAIL reset_stream: got v=%b d=%h be=%h l=%b expected all zero",
               wvalid, wdata, wbe, wlast);
    end
    checks++;
    if (req !== '0) begin
      errors++;
      $display("FAIL reset_req: got %h expected 0", req);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (arready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got rdy=%b busy=%b expected 1 0", arready, busy);
    end
  endtask

  task automatic test_basic_latency();
    clear_obs();
    @(posedge clk); #1;
    arvalid = 1'b1;
    araddr  = 32'h1000_0002;
    arlen   = LenW'(12);
    @(negedge clk);
    checks++;
    if (arready !== 1'b1) begin
      errors++;
      $display("FAIL lat_accept: got arready=%b expected 1", arready);
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (req.req !== 1'b1 || req.addr !== 32'h1000_0000 || req.we !== 1'b0 || req.be !== 4'hF)
    begin
      errors++;
      $display("FAIL lat_req: got req=%b addr=%h we=%b be=%h expected 1 10000000 0 f",
               req.req, req.addr, req.we, req.be);
    end
    @(negedge clk);
    checks++;
    if (wvalid !== 1'b0) begin
      errors++;
      $display("FAIL lat_wvalid_c2: got %b expected 0", wvalid);
    end
    @(negedge clk);
    checks++;
    if (wvalid !== 1'b1 || wdata !== memf(32'h1000_0000)) begin
      errors++;
      $display("FAIL lat_wvalid_c3: got v=%b d=%h expected v=1 d=%h", wvalid, wdata,
               memf(32'h1000_0000));
    end
    wait_idle("basic");
    check_stream(32'h1000_0002, 12, 3, 1, "basic");
    check_done(1, "basic");
    checks++;
    if (done_on_last != 1) begin
      errors++;
      $display("FAIL basic_done_last: got %0d expected 1", done_on_last);
    end
  endtask

  task automatic test_len7();
    clear_obs();
    send_cmd(32'h2000_0040, 7);
    wait_idle("len7");
    check_stream(32'h2000_0040, 7, 2, 1, "len7");
    check_done(1, "len7");
  endtask

  task automatic test_len0();
    clear_obs();
    @(posedge clk); #1;
    arvalid = 1'b1;
    araddr  = 32'h3000_0000;
    arlen   = '0;
    @(negedge clk);
    @(posedge clk); #1;
    arvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL len0_done_next: got %b expected 1", done);
    end
    repeat (5) @(negedge clk);
    check_done(1, "len0");
    checks++;
    if (gnt_addr.size() != 0 || got_d.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL len0_quiet: got grants=%0d words=%0d busy=%b expected 0 0 0",
               gnt_addr.size(), got_d.size(), busy);
    end
  endtask

  task automatic test_backpressure();
    clear_obs();
    wr_pct = 0;
    send_cmd(32'h4000_0100, 64);
    repeat (20) @(negedge clk);
    checks++;
    if (gnt_addr.size() != 4 || req.req !== 1'b0) begin
      errors++;
      $display("FAIL bp_credit: got grants=%0d req=%b expected 4 0", gnt_addr.size(), req.req);
    end
    wr_pct = 100;
    wait_idle("bp");
    check_stream(32'h4000_0100, 64, 16, 1, "bp");
    check_done(1, "bp");
  endtask

  task automatic test_random();
    logic [31:0] a;
    int len;
    for (int k = 0; k < 8; k++) begin
      clear_obs();
      gnt_pct = 30 + int'($urandom_range(70));
      rsp_pct = 30 + int'($urandom_range(70));
      wr_pct  = 30 + int'($urandom_range(70));
      a   = $urandom;
      len = int'($urandom_range(40));
      send_cmd(a, len);
      wait_idle("rnd");
      check_stream(a, len, (len + 3) / 4, 1, "rnd");
      check_done(1, "rnd");
    end
    gnt_pct = 100;
    rsp_pct = 100;
    wr_pct  = 100;
  endtask

  task automatic test_abort();
    int n_gnt, viol;
    bit seen, ok;
    clear_obs();
    rsp_pct = 40;
    send_cmd(32'h5000_0000, 32);
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      if (gnt_addr.size() >= 2) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL abort_setup: got %0d grants expected 2", gnt_addr.size());
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    n_gnt = gnt_addr.size();
    viol = 0;
    ok = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (req.req) viol++;
      if (wvalid) viol++;
      if (!busy) begin
        ok = 1;
        break;
      end
    end
    checks++;
    if (!ok || pend.size() != 0 || rv) begin
      errors++;
      $display("FAIL abort_busy: got idle=%b pending=%0d expected idle with 0 pending",
               ok, pend.size());
    end
    checks++;
    if (viol != 0 || gnt_addr.size() != n_gnt) begin
      errors++;
      $display("FAIL abort_quiet: got %0d req/wvalid cycles, %0d grants expected 0, %0d",
               viol, gnt_addr.size(), n_gnt);
    end
    check_done(0, "abort");
    rsp_pct = 100;
    wait_idle("abort");
  endtask

  task automatic test_abort_idle();
    int len;
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || arready !== 1'b1) begin
      errors++;
      $display("FAIL abort_idle: got busy=%b rdy=%b expected 0 1", busy, arready);
    end
    clear_obs();
    len = 1 + int'($urandom_range(30));
    send_cmd(32'h6000_0008, len);
    wait_idle("post_abort");
    check_stream(32'h6000_0008, len, (len + 3) / 4, 1, "post_abort");
    check_done(1, "post_abort");
  endtask

  task automatic test_bus_error();
    clear_obs();
    err_at = 2;
    send_cmd(32'h7000_0000, 20);
    wait_idle("err");
    err_at = -1;
`ifdef OBI_DMA_ERR_EN
    check_stream(32'h7000_0000, 20, 2, 0, "err");
    check_done(0, "err");
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: got %b expected 1", err);
    end
    clear_obs();
    send_cmd(32'h7000_1000, 4);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: got %b expected 0", err);
    end
    wait_idle("err_next");
    check_stream(32'h7000_1000, 4, 1, 1, "err_next");
`else
    check_stream(32'h7000_0000, 20, 5, 1, "err");
    check_done(1, "err");
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_tied: got %b expected 0", err);
    end
`endif
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 3; k++) begin
      clear_obs();
      send_cmd(32'h8000_0000 + 32'(k * 64), 16 + k);
      wait_idle("b2b");
      check_stream(32'h8000_0000 + 32'(k * 64), 16 + k, (16 + k + 3) / 4, 1, "b2b");
      check_done(1, "b2b");
    end
  endtask

  initial begin
    test_reset();
    test_basic_latency();
    test_len7();
    test_len0();
    test_backpressure();
    test_random();
    test_abort();
    test_abort_idle();
    test_bus_error();
    test_back_to_back();
    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
